// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that shares one fixed-latency 16x16 multiplier among N_REQ clients.
// A tag pipeline records which client owns each in-flight product and routes results back.
module booth_mul_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned LATENCY = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_en,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [16*N_REQ-1:0]  req_a,
    input  logic [16*N_REQ-1:0]  req_b,
    input  logic [2*N_REQ-1:0]   req_sm,
    output logic                 m_v_in,
    output logic [15:0]          m_a,
    output logic [15:0]          m_b,
    output logic [1:0]           m_sm,
    input  logic [31:0]          m_p,
    input  logic                 m_v_out,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [31:0]          rsp_p,
    output logic                 busy,
    output logic                 sync_err
);
    localparam int unsigned ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned WARM_W = $clog2(LATENCY + 1);

    logic [ID_W-1:0]    r_ptr;
    logic               r_m_v_in;
    logic [15:0]        r_m_a;
    logic [15:0]        r_m_b;
    logic [1:0]         r_m_sm;
    logic [ID_W-1:0]    r_issue_id;
    logic [LATENCY-1:0] r_tag_v;
    logic [ID_W-1:0]    r_tag_id [LATENCY];
    logic [N_REQ-1:0]   r_rsp_valid;
    logic [31:0]        r_rsp_p;
    logic               r_sync_err;
    logic [WARM_W-1:0]  r_warm;

    logic               w_accept;
    logic [ID_W-1:0]    w_grant_id;
    logic [15:0]        w_a;
    logic [15:0]        w_b;
    logic [1:0]         w_sm;
    logic               w_tail_v;
    logic [ID_W-1:0]    w_tail_id;
    logic               w_warm_done;

    // Rotating priority: scan ids at or above the pointer first, then wrap to the low ids.
    always_comb begin
        w_accept   = 1'b0;
        w_grant_id = '0;
        if (issue_en) begin
            for (int unsigned j = 0; j < N_REQ; j++) begin
                if (!w_accept && req_valid[j] && (ID_W'(j) >= r_ptr)) begin
                    w_accept   = 1'b1;
                    w_grant_id = ID_W'(j);
                end
            end
            for (int unsigned j = 0; j < N_REQ; j++) begin
                if (!w_accept && req_valid[j] && (ID_W'(j) < r_ptr)) begin
                    w_accept   = 1'b1;
                    w_grant_id = ID_W'(j);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        w_a       = '0;
        w_b       = '0;
        w_sm      = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (ID_W'(j) == w_grant_id) begin
                req_ready[j] = w_accept;
                w_a          = req_a[16*j +: 16];
                w_b          = req_b[16*j +: 16];
                w_sm         = req_sm[2*j +: 2];
            end
        end
    end

    assign w_tail_v    = r_tag_v[LATENCY-1];
    assign w_tail_id   = r_tag_id[LATENCY-1];
    assign w_warm_done = (r_warm == WARM_W'(LATENCY));

    // Issue stage: operand registers only move on an accept; the id rides alongside m_v_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_m_v_in   <= 1'b0;
            r_m_a      <= '0;
            r_m_b      <= '0;
            r_m_sm     <= '0;
            r_issue_id <= '0;
        end else begin
            r_m_v_in <= w_accept;
            if (w_accept) begin
                r_m_a      <= w_a;
                r_m_b      <= w_b;
                r_m_sm     <= w_sm;
                r_issue_id <= w_grant_id;
                r_ptr      <= (w_grant_id == ID_W'(N_REQ - 1)) ? '0 : w_grant_id + 1'b1;
            end
        end
    end

    // Tags trail the issue stage by LATENCY cycles so the tail lines up with m_v_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                r_tag_id[i] <= '0;
            end
        end else begin
            r_tag_v[0]  <= r_m_v_in;
            r_tag_id[0] <= r_issue_id;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    // Response steering and sync monitor; m_v_out is untrusted until the multiplier has flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
            r_rsp_p     <= '0;
            r_sync_err  <= 1'b0;
            r_warm      <= '0;
        end else begin
            for (int unsigned j = 0; j < N_REQ; j++) begin
                r_rsp_valid[j] <= w_tail_v && (w_tail_id == ID_W'(j));
            end
            if (w_tail_v) begin
                r_rsp_p <= m_p;
            end
            if (!w_warm_done) begin
                r_warm <= r_warm + 1'b1;
            end
            if (w_warm_done && (m_v_out != w_tail_v)) begin
                r_sync_err <= 1'b1;
            end
        end
    end

    assign m_v_in    = r_m_v_in;
    assign m_a       = r_m_a;
    assign m_b       = r_m_b;
    assign m_sm      = r_m_sm;
    assign rsp_valid = r_rsp_valid;
    assign rsp_p     = r_rsp_p;
    assign sync_err  = r_sync_err;
    assign busy      = (|r_tag_v) | r_m_v_in | w_accept;

endmodule
